bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the serial pattern-detector FSMs. Accepts WIDTH-bit words over a valid/ready handshake, buffers one word, and drives them out MSB-first one bit per enabled clock on `ser_out`. Its output connects directly to the detector's `in` port. Back-to-back words stream with no idle bit between them.

## Interface
- `WIDTH`, default 8: word width in bits, must be ≥ 2.
- `CNT_W`, default `$clog2(WIDTH)`: bit-index counter width; derived, not overridden.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `load_valid` input 1: producer presents a word on `load_data`.
- `load_ready` output 1: block can accept a word this cycle.
- `load_data` input WIDTH: word to serialize, MSB sent first.
- `shift_en` input 1: advance one bit this cycle; when 0, output and state are frozen.
- `ser_out` output 1: serial bit, feeds the detector's `in`.
- `ser_valid` output 1: `ser_out` carries a real data bit.
- `word_done` output 1: one-cycle pulse after the last bit of a word is consumed.
- `busy` output 1: shifter or hold buffer is occupied.

## Operation
- Two storage elements:
  - Hold buffer: `hold_data` plus `hold_valid`.
  - Shifter: `shift_reg` plus bit index `idx`.
- FSM states are IDLE and SHIFT.
- Accept rule:
  - `load_ready = !hold_valid`, taken from registered state only, with no combinational path from `load_valid`.
  - A handshake (`load_valid && load_ready`) writes `hold_data` and sets `hold_valid`.
- Transfer rule: hold moves to the shifter at an edge when `hold_valid` is 1 and either condition holds:
  - state is IDLE, or
  - state is SHIFT, `idx == 0`, and `shift_en == 1`.
- On transfer:
  - `shift_reg <= hold_data`, `idx <= WIDTH-1`, `hold_valid <= 0`.
  - State becomes or stays SHIFT.
- Handshake and transfer in the same cycle cannot occur, because `load_ready` is low whenever `hold_valid` is high.
- Behaviour in SHIFT:
  - `ser_out = shift_reg[idx]` and `ser_valid = 1`.
  - With `shift_en = 1` and `idx > 0`: decrement `idx`.
  - With `shift_en = 1`, `idx == 0`, and hold empty: return to IDLE.
  - With `shift_en = 0`: nothing changes.
- In IDLE: `ser_out = 0` and `ser_valid = 0`.
- `word_done` is registered. It is set for one cycle on the edge where SHIFT with `idx == 0` and `shift_en == 1` is consumed.
- `busy = hold_valid || (state == SHIFT)`.
- `shift_en` affects only the shifter. The hold buffer still accepts words while `shift_en = 0`.

## Timing
- Reset values:
  - State IDLE; `hold_valid`, `ser_out`, `ser_valid`, `word_done`, `busy` all 0.
  - `load_ready` 1; `idx` 0; data registers 0.
- Reset mid-word aborts the word immediately (asynchronous). The partial word and the held word are discarded.
- Latency from a handshake at edge E0 when idle:
  - Transfer at E1.
  - First bit valid on `ser_out` after E1.
- With `shift_en` held at 1, a word occupies exactly WIDTH cycles of `ser_valid`.
- Gapless streaming: if `hold_valid` is set before bit 0 is consumed, the MSB of the next word follows bit 0 on the very next cycle.
- `load_ready` rises the cycle after a transfer.
- `ser_out` is a registered output with no glitches. The detector samples it on the same `clk` edge on which it advances.

## Structure
- Shared package `serial_pkg` holds:
  - State encoding localparams: `S_IDLE = 1'b0`, `S_SHIFT = 1'b1`.
  - Default `WIDTH` constant, shared with the detector benches.
- One sub-module, `word_hold_reg`: the one-entry buffer, with ports `clk`, `rst`, `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`.
- The top level contains the FSM, the shifter, the index counter, and the output registers.

## Test plan
- Single word:
  - Stimulus: `load_data = 8'b1010_1010`, `shift_en = 1`.
  - Required: `ser_out` = 1,0,1,0,1,0,1,0 over 8 cycles, starting 2 edges after the handshake; `word_done` pulses once; then IDLE with `ser_valid = 0`.
- Back-to-back:
  - Stimulus: words `8'hAA` then `8'h55`, the second offered while the first shifts.
  - Required: 16 consecutive `ser_valid` cycles, bit stream 10101010_01010101 with no gap; `load_ready` low from acceptance of `8'h55` until its transfer.
- Stall:
  - Stimulus: `shift_en = 0` for 3 cycles after bit 5 of `8'hAA`.
  - Required: `ser_out` and `idx` are frozen for 3 cycles; the total word spans 11 cycles; the bit order is unchanged.
- Backpressure:
  - Stimulus: `load_valid` held with three words queued.
  - Required: exactly one word held while the shifter is busy; no word is lost or duplicated; the output order matches the input order.
- Reset mid-operation:
  - Stimulus: `rst` low after bit 3 of `8'hAA`, with `8'h55` held.
  - Required: all outputs go to their reset values at once; after release, a new word `8'hF0` serializes cleanly as 11110000.
- Detector integration:
  - Stimulus: feed `8'b1010_1010` into the pattern detector.
  - Required: the detector output asserts after the 7th bit, on the 1010101 pattern.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serializer and the serial pattern-detector benches.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package serial_pkg;

  // State encoding, fixed so detector benches can decode a probed state bit.
  localparam logic S_IDLE  = 1'b0;
  localparam logic S_SHIFT = 1'b1;

  // Default word width, shared with the detector benches.
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT
  } ser_state_e;

endpackage

// File: rtl/word_hold_reg.sv
// One-entry word buffer sitting between the load handshake and the shifter.
// Latency: a write is visible on rd_data/full one cycle after wr_en.
// Backpressure: full stays high until rd_en drains the entry; the owner must not write while full.
module word_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  // Next-state: a read empties the entry, a write fills it (never both in one cycle).
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (rd_en) begin
      full_d = 1'b0;
    end
    if (wr_en) begin
      data_d = wr_data;
      full_d = 1'b1;
    end
  end

  // Entry storage with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign rd_data = data_q;
  assign full    = full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one held word plus an MSB-first shifter driving ser_out.
// Latency: handshake at edge E0, transfer to shifter at E1, first bit on ser_out after E1.
// Backpressure: load_ready = hold buffer empty; shift_en=0 freezes the shifter but not the hold buffer.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             word_done_q, word_done_d;

  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;
  logic             handshake;
  logic             last_bit;
  logic             transfer;

  // load_ready depends on registered state only, so there is no path from load_valid.
  assign load_ready = !hold_valid;
  assign handshake  = load_valid && load_ready;

  // The final bit of the current word is consumed on this edge.
  assign last_bit = (state_q == ST_SHIFT) && (idx_q == '0) && shift_en;

  // Refill the shifter when idle, or seamlessly right as the last bit leaves.
  assign transfer = hold_valid && ((state_q == ST_IDLE) || last_bit);

  word_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (handshake),
    .wr_data(load_data),
    .rd_en  (transfer),
    .rd_data(hold_data),
    .full   (hold_valid)
  );

  // FSM next state, shifter/index update and the pre-computed registered outputs.
  always_comb begin
    state_d     = state_q;
    shift_reg_d = shift_reg_q;
    idx_d       = idx_q;
    word_done_d = last_bit;

    if (transfer) begin
      state_d     = ST_SHIFT;
      shift_reg_d = hold_data;
      idx_d       = CNT_W'(WIDTH - 1);
    end else if ((state_q == ST_SHIFT) && shift_en) begin
      if (idx_q != '0) begin
        idx_d = idx_q - 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end

    // Registering the next bit keeps ser_out glitch-free and aligned with state.
    ser_valid_d = (state_d == ST_SHIFT);
    ser_out_d   = (state_d == ST_SHIFT) ? shift_reg_d[idx_d] : 1'b0;
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shift_reg_q <= '0;
      idx_q       <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_reg_q <= shift_reg_d;
      idx_q       <= idx_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      word_done_q <= word_done_d;
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign word_done = word_done_q;
  assign busy      = hold_valid || (state_q == ST_SHIFT);

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: vector table, corner-case sequences, random stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_bit_serializer;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_data;
  logic       shift_en;
  logic       ser_out;
  logic       ser_valid;
  logic       word_done;
  logic       busy;

  int n_vec;
  int n_bad;

  // Observations gathered by cyc(): accepted words, consumed bits, done pulses.
  logic [7:0] acc_q[$];
  logic       bit_q[$];
  int         n_done;
  logic       last_hs;

  typedef struct {
    logic       lv;
    logic [7:0] d;
    logic       se;
    logic       e_out;
    logic       e_vld;
    logic       e_done;
    logic       e_rdy;
    logic       e_busy;
  } vec_t;

  vec_t tbl[11];

  bit_serializer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .shift_en  (shift_en),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .word_done (word_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, record what the edge will consume/accept, advance to edge+1.
  task automatic cyc(input logic lv, input logic [7:0] d, input logic se);
    load_valid = lv;
    load_data  = d;
    shift_en   = se;
    last_hs    = lv && load_ready;
    if (last_hs) acc_q.push_back(d);
    if (ser_valid && se) bit_q.push_back(ser_out);
    if (word_done) n_done++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    acc_q.delete();
    bit_q.delete();
    n_done = 0;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    shift_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_obs();
  endtask

  // Compare consumed bits against the concatenation of the given words, MSB first.
  task automatic chk_stream(input string nm, input logic [7:0] words[$]);
    chk({nm, "_len"}, bit_q.size(), words.size() * 8);
    for (int w = 0; w < words.size(); w++) begin
      logic [7:0] got;
      got = 8'h00;
      for (int b = 0; b < 8; b++) begin
        if (w * 8 + b < bit_q.size()) got[7-b] = bit_q[w*8+b];
      end
      chk({nm, "_word"}, got, words[w]);
    end
  endtask

  initial begin
    logic [7:0] exp_words[$];
    logic [7:0] aa;
    logic [7:0] bp_words[3];
    logic [15:0] b2b;
    logic [10:0] stall_out;
    logic [10:0] stall_se;
    logic [6:0] win;
    int p;
    int det_pos;

    n_vec = 0;
    n_bad = 0;
    aa = 8'hAA;

    // lv, d, se, out, vld, done, rdy, busy
    tbl[0]  = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset values.
    do_reset();
    chk("rst_ready", load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", ser_valid, 0);
    chk("rst_out", ser_out, 0);
    chk("rst_done", word_done, 0);

    // Single word from the vector table.
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].lv, tbl[i].d, tbl[i].se);
      chk($sformatf("tbl%0d_out", i), ser_out, tbl[i].e_out);
      chk($sformatf("tbl%0d_vld", i), ser_valid, tbl[i].e_vld);
      chk($sformatf("tbl%0d_done", i), word_done, tbl[i].e_done);
      chk($sformatf("tbl%0d_rdy", i), load_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
    end

    // Back-to-back AA then 55 with no gap.
    do_reset();
    b2b = 16'hAA55;
    cyc(1'b1, 8'hAA, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b2b_vld%0d", i), ser_valid, 1);
      chk($sformatf("b2b_bit%0d", i), ser_out, b2b[15-i]);
      if (i >= 1 && i <= 7) chk($sformatf("b2b_rdy_lo%0d", i), load_ready, 0);
      if (i == 0 || i == 8) chk($sformatf("b2b_rdy_hi%0d", i), load_ready, 1);
      cyc(i == 0, 8'h55, 1'b1);
    end
    chk("b2b_end_vld", ser_valid, 0);
    chk("b2b_end_done", word_done, 1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("b2b_ndone", n_done, 2);

    // Stall of 3 cycles after bit 5 of AA: 11 valid cycles, order preserved.
    do_reset();
    stall_se  = 11'b111_000_11111;
    stall_out = 11'b101_000_01010;
    cyc(1'b1, 8'hAA, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("stall_vld%0d", i), ser_valid, 1);
      chk($sformatf("stall_out%0d", i), ser_out, stall_out[10-i]);
      cyc(1'b0, 8'h00, stall_se[10-i]);
    end
    chk("stall_end_vld", ser_valid, 0);
    chk("stall_end_done", word_done, 1);
    exp_words = '{8'hAA};
    chk_stream("stall_stream", exp_words);

    // Backpressure: load_valid held with three words queued.
    do_reset();
    bp_words[0] = 8'h3C;
    bp_words[1] = 8'hC3;
    bp_words[2] = 8'h96;
    p = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(p < 3, (p < 3) ? bp_words[p] : 8'h00, 1'b1);
      if (last_hs) begin
        p++;
        chk($sformatf("bp_hold_full%0d", p), load_ready, 0);
      end
    end
    chk("bp_accepted", p, 3);
    chk("bp_ndone", n_done, 3);
    exp_words = '{8'h3C, 8'hC3, 8'h96};
    chk_stream("bp_stream", exp_words);

    // Reset in the middle of AA with 55 held.
    do_reset();
    cyc(1'b1, 8'hAA, 1'b1);
    cyc(1'b1, 8'h55, 1'b1);
    cyc(1'b1, 8'h55, 1'b1);
    repeat (4) cyc(1'b0, 8'h00, 1'b1);
    chk("mid_busy_pre", busy, 1);
    chk("mid_rdy_pre", load_ready, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_out", ser_out, 0);
    chk("mid_rst_vld", ser_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdy", load_ready, 1);
    chk("mid_rst_done", word_done, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_obs();
    cyc(1'b1, 8'hF0, 1'b1);
    repeat (12) cyc(1'b0, 8'h00, 1'b1);
    exp_words = '{8'hF0};
    chk_stream("mid_f0", exp_words);
    chk("mid_ndone", n_done, 1);

    // Detector integration: 1010101 seen on exactly the 7th bit of AA.
    do_reset();
    cyc(1'b1, aa, 1'b1);
    repeat (11) cyc(1'b0, 8'h00, 1'b1);
    win = 7'b0;
    det_pos = 0;
    for (int i = 0; i < bit_q.size(); i++) begin
      win = {win[5:0], bit_q[i]};
      if (det_pos == 0 && i >= 6 && win == 7'b1010101) det_pos = i + 1;
    end
    chk("det_pos", det_pos, 7);

    // Random traffic against a word-queue reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (30) cyc(1'b0, 8'h00, 1'b1);
    chk("rnd_ndone", n_done, acc_q.size());
    chk("rnd_len", bit_q.size(), acc_q.size() * 8);
    for (int w = 0; w < acc_q.size(); w++) begin
      for (int b = 0; b < 8; b++) begin
        if (w * 8 + b < bit_q.size()) begin
          logic [7:0] wd;
          wd = acc_q[w];
          chk($sformatf("rnd_w%0d_b%0d", w, 7 - b), bit_q[w*8+b], wd[7-b]);
        end
      end
    end
    chk("rnd_idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
